// File: rtl/mux_scan_controller.sv
// -----------------------------------------------------------------------------
// mux_scan_controller
//
// Walks the 4-bit select of an external 16-to-1 mux through channels 0..15,
// holding each select value for DWELL cycles and sampling the mux output W on
// the last cycle of each dwell. The 16 samples collect in a shadow word that
// is copied into data in one go when channel 15 is sampled, so data only
// ever shows complete scans.
//
// Parameters
//   DWELL   cycles each select value is held before sampling (1..15)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   scan request (ignored while a scan is running)
//   mux_w   in   mux output W, combinational on sel
//   sel     out  [3:0] mux select
//   mux_en  out  mux enable, high while scanning
//   busy    out  high while scanning
//   done    out  one-cycle pulse in the cycle data has just been updated
//   data    out  [15:0] last completed scan, bit i = W sampled at sel=i
//   parity  out  XOR of the 16 bits loaded into data
//                (present only when SCAN_PARITY_EN is defined)
//
// Build option: define SCAN_PARITY_EN to add the parity output.
// -----------------------------------------------------------------------------
module mux_scan_controller #(
  parameter int DWELL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mux_w,
  output logic [3:0]  sel,
  output logic        mux_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] data
`ifdef SCAN_PARITY_EN
  ,
  output logic        parity
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  logic [1:0]  state_q,  state_d;
  logic [3:0]  sel_q,    sel_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] data_q,   data_d;
  logic        mux_en_q, mux_en_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  // Last cycle of a dwell: W is sampled into the shadow at this edge.
  logic sample_en;
  // Sampling channel 15 finishes the scan.
  logic scan_last;

  assign sample_en = (state_q == ST_SCAN) && (cnt_q == DWELL_LAST);
  assign scan_last = sample_en && (sel_q == 4'hF);

  // One write-enable per shadow bit, keyed on the channel being sampled.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shadow
      assign shadow_d[gi] = (sample_en && (sel_q == 4'(gi))) ? mux_w : shadow_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    // shadow_d already carries bit 15 sampled at this edge, so data gets
    // the complete word.
    data_d  = scan_last ? shadow_d : data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          sel_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      ST_SCAN: begin
        if (sample_en) begin
          cnt_d = 4'd0;
          sel_d = sel_q + 4'd1;  // wraps 15 -> 0 on the last channel
          if (scan_last) begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SCAN;
          sel_d   = 4'd0;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase

    // Status outputs are decoded from the next state so they come straight
    // off flops and line up with the state they describe.
    mux_en_d = (state_d == ST_SCAN);
    busy_d   = (state_d == ST_SCAN);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 4'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 16'd0;
      data_q   <= 16'd0;
      mux_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      mux_en_q <= mux_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel    = sel_q;
  assign mux_en = mux_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign data   = data_q;

`ifdef SCAN_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = scan_last ? (^shadow_d) : parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_controller.sv
module tb_mux_scan_controller;

  logic        clk;
  logic        rst;

  // Instance with DWELL=1
  logic        start1;
  logic [15:0] a1;
  logic        w1;
  logic [3:0]  sel1;
  logic        en1, busy1, done1;
  logic [15:0] data1;

  // Instance with DWELL=3
  logic        start3;
  logic [15:0] a3;
  logic        w3;
  logic [3:0]  sel3;
  logic        en3, busy3, done3;
  logic [15:0] data3;

`ifdef SCAN_PARITY_EN
  logic        par1, par3;
`endif

  int checks;
  int errors;

  // 16-to-1 mux models: W = A[sel]
  assign w1 = a1[sel1];
  assign w3 = a3[sel3];

  mux_scan_controller #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mux_w(w1),
    .sel(sel1), .mux_en(en1), .busy(busy1), .done(done1), .data(data1)
`ifdef SCAN_PARITY_EN
    , .parity(par1)
`endif
  );

  mux_scan_controller #(.DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mux_w(w3),
    .sel(sel3), .mux_en(en3), .busy(busy3), .done(done3), .data(data3)
`ifdef SCAN_PARITY_EN
    , .parity(par3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    a1     = 16'h0000;
    a3     = 16'h0000;

    // ---------------- reset then idle ----------------
    #1;
    check("rst_sel1",  {28'd0, sel1},  32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_data3", {16'd0, data3}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_sel1",  {28'd0, sel1},  32'd0);
      check("idle_en1",   {31'd0, en1},   32'd0);
      check("idle_busy1", {31'd0, busy1}, 32'd0);
      check("idle_done1", {31'd0, done1}, 32'd0);
      check("idle_data1", {16'd0, data1}, 32'h0000);
      check("idle_busy3", {31'd0, busy3}, 32'd0);
    end
    $display("reset/idle: done");

    // ---------------- single scan, DWELL=1, A=A5C3 ----------------
    a1 = 16'hA5C3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("s1_sel",  {28'd0, sel1},  32'(i));
      check("s1_en",   {31'd0, en1},   32'd1);
      check("s1_busy", {31'd0, busy1}, 32'd1);
      check("s1_done", {31'd0, done1}, 32'd0);
      check("s1_data_hold", {16'd0, data1}, 32'h0000);
      tick();
    end
    check("s1_done_pulse", {31'd0, done1}, 32'd1);
    check("s1_done_busy",  {31'd0, busy1}, 32'd0);
    check("s1_done_en",    {31'd0, en1},   32'd0);
    check("s1_done_sel",   {28'd0, sel1},  32'd0);
    check("s1_data",       {16'd0, data1}, 32'hA5C3);
`ifdef SCAN_PARITY_EN
    check("s1_parity", {31'd0, par1}, 32'd0);
`endif
    tick();
    check("s1_after_done", {31'd0, done1}, 32'd0);
    check("s1_after_busy", {31'd0, busy1}, 32'd0);
    check("s1_after_data", {16'd0, data1}, 32'hA5C3);
    $display("single scan DWELL=1: data=%h", data1);

    // ---------------- DWELL=3, A=8001 ----------------
    a3 = 16'h8001;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int j = 0; j < 48; j++) begin
      check("d3_sel",  {28'd0, sel3},  32'(j / 3));
      check("d3_en",   {31'd0, en3},   32'd1);
      check("d3_done", {31'd0, done3}, 32'd0);
      tick();
    end
    check("d3_done_pulse", {31'd0, done3}, 32'd1);
    check("d3_data",       {16'd0, data3}, 32'h8001);
`ifdef SCAN_PARITY_EN
    check("d3_parity", {31'd0, par3}, 32'd0);
`endif
    tick();
    check("d3_after_done", {31'd0, done3}, 32'd0);
    $display("single scan DWELL=3: data=%h", data3);

    // ---------------- back-to-back scans ----------------
    a1 = 16'h1234;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("b2b_done1", {31'd0, done1}, 32'd1);
    check("b2b_data1", {16'd0, data1}, 32'h1234);
`ifdef SCAN_PARITY_EN
    check("b2b_par1", {31'd0, par1}, 32'd1);
`endif
    a1 = 16'hFFFE;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("b2b_restart_busy", {31'd0, busy1}, 32'd1);
    check("b2b_restart_sel",  {28'd0, sel1},  32'd0);
    check("b2b_restart_done", {31'd0, done1}, 32'd0);
    check("b2b_data_hold",    {16'd0, data1}, 32'h1234);
    for (int i = 0; i < 16; i++) tick();
    check("b2b_done2", {31'd0, done1}, 32'd1);
    check("b2b_data2", {16'd0, data1}, 32'hFFFE);
`ifdef SCAN_PARITY_EN
    check("b2b_par2", {31'd0, par1}, 32'd1);
`endif
    tick();
    $display("back-to-back: data=%h", data1);

    // ---------------- abort by async reset ----------------
    a1 = 16'hFFFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("abort_sel7", {28'd0, sel1}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sel",  {28'd0, sel1},  32'd0);
    check("abort_en",   {31'd0, en1},   32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_done", {31'd0, done1}, 32'd0);
    check("abort_data", {16'd0, data1}, 32'h0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle_busy", {31'd0, busy1}, 32'd0);
      check("abort_idle_data", {16'd0, data1}, 32'h0000);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("abort_new_sel", {28'd0, sel1}, 32'd0);
    for (int i = 0; i < 16; i++) tick();
    check("abort_new_done", {31'd0, done1}, 32'd1);
    check("abort_new_data", {16'd0, data1}, 32'hFFFF);
    tick();
    $display("abort/rescan: data=%h", data1);

    // ---------------- start held high across a scan ----------------
    a1 = 16'h00FF;
    start1 = 1'b1;
    tick();
    check("hold_sel0", {28'd0, sel1}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("hold_sel",  {28'd0, sel1},  32'(i));
      check("hold_busy", {31'd0, busy1}, 32'd1);
      check("hold_done", {31'd0, done1}, 32'd0);
    end
    tick();
    check("hold_done_pulse", {31'd0, done1}, 32'd1);
    check("hold_data",       {16'd0, data1}, 32'h00FF);
`ifdef SCAN_PARITY_EN
    check("hold_parity", {31'd0, par1}, 32'd0);
`endif
    tick();
    check("hold_rescan_busy", {31'd0, busy1}, 32'd1);
    check("hold_rescan_sel",  {28'd0, sel1},  32'd0);
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("hold_rescan_done", {31'd0, done1}, 32'd1);
    check("hold_rescan_data", {16'd0, data1}, 32'h00FF);
    tick();
    check("hold_end_busy", {31'd0, busy1}, 32'd0);
    $display("start held: data=%h", data1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 SHALL have parameter DWELL, default 1, meaning cycles each select value is held before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  scan request, sampled on clk.
REQ-005 SHALL have port mux_w  input  1  output W of the downstream 16-to-1 mux, combinational on sel.
REQ-006 SHALL have port sel  output  4  select driven to the mux S input.
REQ-007 SHALL have port mux_en  output  1  enable driven to the mux en input.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when data is updated.
REQ-010 SHALL have port data  output  16  last completed scan, bit i = mux_w sampled with sel=i.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-012 In IDLE: sel=0, mux_en=0, busy=0, done=0; start=1 at an edge moves to SCAN with sel=0 and dwell counter=0.
REQ-013 In SCAN: mux_en=1, busy=1; the dwell counter increments each cycle; when it equals DWELL-1, mux_w is written into shadow bit [sel], the counter clears and sel increments.
REQ-014 When shadow bit 15 is written, the FSM moves to DONE at that edge; sel wraps to 0.
REQ-015 At the SCAN->DONE edge, data SHALL load the full shadow word, including bit 15 sampled at that edge.
REQ-016 In DONE: done=1, busy=0, mux_en=0, for exactly one cycle.
REQ-017 From DONE, start=1 SHALL go directly to SCAN (back-to-back scans); otherwise DONE SHALL go to IDLE.
REQ-018 start while in SCAN SHALL be ignored; the scan SHALL neither restart nor queue.
REQ-019 Latency: start accepted at edge k SHALL give done=1 in the cycle after edge k+16*DWELL.
REQ-020 data SHALL hold its value except at the SCAN->DONE edge; a partial scan SHALL never update data.
REQ-021 sel, mux_en, busy and done SHALL be registered, with no combinational path from start or mux_w.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, sel=0, mux_en=0, busy=0, done=0, dwell counter=0, shadow=0, data=0, regardless of clk.
REQ-023 rst asserted mid-SCAN SHALL abort the scan; after release, the next start SHALL begin again at channel 0.

Configuration
REQ-024 With macro SCAN_PARITY_EN defined, the module SHALL add output parity (1 bit), loaded with the XOR of all 16 shadow bits at the SCAN->DONE edge, reset to 0, and held otherwise.
REQ-025 Without SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Reset then idle: assert rst for 3 cycles, then hold start=0 for 10 cycles -> sel=0, mux_en=0, busy=0, done=0, data=16'h0000 throughout.
REQ-027 Single scan, DWELL=1, mux model with A=16'hA5C3: pulse start for 1 cycle -> sel steps 0..15 over 16 cycles with mux_en=1, done pulses once in cycle 17, data=16'hA5C3; with SCAN_PARITY_EN, parity=0.
REQ-028 DWELL=3, A=16'h8001: pulse start -> each sel value is held 3 cycles, done arrives 49 cycles after the start edge, data=16'h8001.
REQ-029 Back-to-back: A=16'h1234, then A changed to 16'hFFFE during the done cycle with start=1 -> second scan starts with no IDLE cycle and data ends at 16'hFFFE; with SCAN_PARITY_EN, parity=1.
REQ-030 Abort: start a scan with A=16'hFFFF, assert rst asynchronously at sel=7 -> outputs are zero immediately and data stays 16'h0000; a new scan then yields data=16'hFFFF.
REQ-031 start held high for the whole scan (A=16'h00FF) -> one scan completes with data=16'h00FF and no restart mid-scan; a new scan begins from DONE per REQ-017.
